// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writebacks (port A, never back-pressured) with a
// multicycle unit's writebacks (port B, 2-entry FIFO) onto one register-file
// write port. A has priority; a starvation counter forces a one-cycle A stall
// so that a queued B write cannot wait forever.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic        stall_a,
    output logic [1:0]  pend_count,
    output logic        err
);

    logic [1:0][4:0]  fifo_reg;
    logic [1:0][31:0] fifo_data;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [3:0]       starve_cnt;

    logic grant_a;
    logic grant_b;
    logic push;
    logic waiting;
    logic starve_hit;

    // Readiness depends only on occupancy before this cycle's pop, so a full
    // FIFO refuses a push even while its head drains. Held low during reset.
    assign b_ready    = reset && (count != 2'd2);
    assign pend_count = count;

    // Per-cycle arbitration, push qualification and starvation detection
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        push       = 1'b0;
        waiting    = 1'b0;
        starve_hit = 1'b0;
        grant_a    = !stall_a && a_valid;
        grant_b    = !grant_a && (count != 2'd0);
        push       = b_valid && b_ready && (b_reg != 5'd0);
        waiting    = (count != 2'd0) && !grant_b;
        starve_hit = waiting && (starve_cnt == 4'(STARVE_LIMIT));
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_reg  <= '0;
            fifo_data <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= '0;
        end else begin
            if (push) begin
                fifo_reg[wr_ptr]  <= b_reg;
                fifo_data[wr_ptr] <= b_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (grant_b) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(grant_b);
        end
    end

    // Starvation counter and the one-cycle A stall it triggers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_a    <= 1'b0;
        end else begin
            // The counter clears on the cycle that raises the stall so it never
            // runs past STARVE_LIMIT; the head is then granted during the stall.
            if (!waiting || starve_hit) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            stall_a <= starve_hit;
        end
    end

    // Sticky flag for an A request presented while A was told to stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (a_valid && stall_a) begin
            err <= 1'b1;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
        end else if (grant_a) begin
            RegWrite       <= (a_reg != 5'd0);
            Write_register <= a_reg;
            Write_data     <= a_data;
        end else if (grant_b) begin
            RegWrite       <= 1'b1;
            Write_register <= fifo_reg[rd_ptr];
            Write_data     <= fifo_data[rd_ptr];
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic        stall_a;
    logic [1:0]  pend_count;
    logic        err;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .reset(reset),
        .a_valid(a_valid),
        .a_reg(a_reg),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_reg(b_reg),
        .b_data(b_data),
        .RegWrite(RegWrite),
        .Write_register(Write_register),
        .Write_data(Write_data),
        .stall_a(stall_a),
        .pend_count(pend_count),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          m_starve;
    bit          m_stall;
    bit          m_err;
    bit          m_we;
    bit          m_known;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_stall  = 0;
        m_err    = 0;
        m_we     = 0;
        m_known  = 1;
        m_wreg   = '0;
        m_wdata  = '0;
    endtask

    // One clock edge of the arbitration rules, using pre-edge model state
    task automatic model_step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                              input bit bv, input logic [4:0] br, input logic [31:0] bd);
        int   sz;
        bit   ga;
        bit   gb;
        bit   accept;
        ent_t e;
        sz     = q.size();
        ga     = !m_stall && av;
        gb     = !ga && (sz > 0);
        accept = bv && (sz < 2);
        if (av && m_stall) m_err = 1;
        if (ga) begin
            m_we    = (ar != 0);
            m_known = (ar != 0);
            m_wreg  = ar;
            m_wdata = ad;
        end else if (gb) begin
            e       = q.pop_front();
            m_we    = 1;
            m_known = 1;
            m_wreg  = e.r;
            m_wdata = e.d;
        end else begin
            m_we = 0;
        end
        if (sz > 0 && !gb) begin
            if (m_starve == LIMIT) begin
                m_stall  = 1;
                m_starve = 0;
            end else begin
                m_stall  = 0;
                m_starve = m_starve + 1;
            end
        end else begin
            m_stall  = 0;
            m_starve = 0;
        end
        if (accept && br != 0) begin
            e.r = br;
            e.d = bd;
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        check("RegWrite", 32'(RegWrite), 32'(m_we));
        if (m_known) begin
            check("Write_register", 32'(Write_register), 32'(m_wreg));
            check("Write_data", Write_data, m_wdata);
        end
        check("stall_a", 32'(stall_a), 32'(m_stall));
        check("err", 32'(err), 32'(m_err));
        check("pend_count", 32'(pend_count), 32'(q.size()));
        check("b_ready", 32'(b_ready), 32'(q.size() < 2));
    endtask

    // Entered at a negedge: check, drive, advance one edge, return at next negedge
    task automatic run_cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                             input bit bv, input logic [4:0] br, input logic [31:0] bd);
        check_outputs();
        a_valid = av;
        a_reg   = ar;
        a_data  = ad;
        b_valid = bv;
        b_reg   = br;
        b_data  = bd;
        @(posedge clk);
        model_step(av, ar, ad, bv, br, bd);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_RegWrite"}, 32'(RegWrite), 32'd0);
        check({tag, "_Write_register"}, 32'(Write_register), 32'd0);
        check({tag, "_Write_data"}, Write_data, 32'd0);
        check({tag, "_stall_a"}, 32'(stall_a), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_pend_count"}, 32'(pend_count), 32'd0);
        check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("b_ready_after_release", 32'(b_ready), 32'd1);
        model_reset();
    endtask

    int seen;
    int total_writes;

    initial begin
        reset   = 1'b0;
        a_valid = 0; a_reg = '0; a_data = '0;
        b_valid = 0; b_reg = '0; b_data = '0;
        model_reset();
        apply_reset();

        // A-only write, then idle
        run_cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check("a_only_we", 32'(RegWrite), 32'd1);
        check("a_only_reg", 32'(Write_register), 32'd5);
        check("a_only_data", Write_data, 32'hDEADBEEF);
        run_cycle(0, 0, 0, 0, 0, 0);
        check("a_only_we_off", 32'(RegWrite), 32'd0);

        // B-only: enqueue in N, pending in N+1, written in N+2
        run_cycle(0, 0, 0, 1, 5'd9, 32'h1234);
        check("b_only_pend1", 32'(pend_count), 32'd1);
        check("b_only_we_early", 32'(RegWrite), 32'd0);
        run_cycle(0, 0, 0, 0, 0, 0);
        check("b_only_we", 32'(RegWrite), 32'd1);
        check("b_only_reg", 32'(Write_register), 32'd9);
        check("b_only_data", Write_data, 32'h1234);
        check("b_only_pend0", 32'(pend_count), 32'd0);

        // Fill the FIFO while A holds the port; register-0 transfers never write
        run_cycle(1, 5'd1, 32'h11, 1, 5'd3, 32'h33);
        run_cycle(1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
        check("full_ready", 32'(b_ready), 32'd0);
        check("full_pend", 32'(pend_count), 32'd2);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 5'd0, 32'hBAD);
        run_cycle(1, 5'd0, 32'hBAD, 0, 0, 0);
        check("reg0_a_we", 32'(RegWrite), 32'd0);
        run_cycle(0, 0, 0, 0, 0, 0);
        check("reg0_b_we", 32'(RegWrite), 32'd0);
        check("reg0_b_pend", 32'(pend_count), 32'd0);

        // Starvation with a well-behaved pipeline: stall 5 cycles after grantable
        run_cycle(1, 5'd7, 32'h77, 1, 5'd12, 32'hC0FFEE);
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            if (stall_a) seen = i;
            run_cycle(!m_stall, 5'd7, 32'(i), 0, 0, 0);
        end
        check("starve_delay", 32'(seen), 32'd5);
        check("starve_b_reg", 32'(Write_register), 32'd12);
        check("starve_b_we", 32'(RegWrite), 32'd1);
        run_cycle(1, 5'd8, 32'h88, 0, 0, 0);
        check("starve_a_resumes", 32'(Write_register), 32'd8);
        check("starve_no_err", 32'(err), 32'd0);

        // Violation: A ignores the stall
        run_cycle(1, 5'd7, 32'h77, 1, 5'd13, 32'hABCD);
        for (int i = 0; i < 20 && !m_err; i++) begin
            run_cycle(1, 5'd7, 32'h100 + 32'(i), 0, 0, 0);
        end
        check("viol_b_reg", 32'(Write_register), 32'd13);
        check("viol_err", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 0, 0);
        check("viol_err_sticky", 32'(err), 32'd1);

        // Reset mid-operation with two queued entries
        run_cycle(1, 5'd1, 32'h1, 1, 5'd20, 32'h2020);
        run_cycle(1, 5'd1, 32'h2, 1, 5'd21, 32'h2121);
        check("midrst_pend", 32'(pend_count), 32'd2);
        a_valid = 0;
        b_valid = 0;
        apply_reset();
        total_writes = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0);
            total_writes += int'(RegWrite);
        end
        check("midrst_no_write", 32'(total_writes), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            run_cycle(($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom(),
                      ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom());
            if (i == 250) begin
                a_valid = 0;
                b_valid = 0;
                apply_reset();
            end
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, legal range 1..15; consecutive wait cycles a queued B write tolerates before A is stalled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 a_valid  input  1  pipeline writeback request (port A); has no ready and cannot be back-pressured.
REQ-005 a_reg  input  5  port A destination register.
REQ-006 a_data  input  32  port A write data.
REQ-007 b_valid  input  1  multicycle-unit writeback request (port B).
REQ-008 b_ready  output  1  port B may transfer this cycle.
REQ-009 b_reg  input  5  port B destination register.
REQ-010 b_data  input  32  port B write data.
REQ-011 RegWrite  output  1  register-file write enable, registered.
REQ-012 Write_register  output  5  register-file write address, registered.
REQ-013 Write_data  output  32  register-file write data, registered.
REQ-014 stall_a  output  1  registered; instructs the pipeline to present no A request this cycle.
REQ-015 pend_count  output  2  number of queued B writes (0..2).
REQ-016 err  output  1  sticky protocol-violation flag.

Function
REQ-017 Port B SHALL use a 2-entry FIFO; b_ready = (pend_count < 2), derived from registered state only; a push occurs when b_valid && b_ready.
REQ-018 A full FIFO SHALL NOT accept a push even in a cycle in which its head is popped.
REQ-019 A B transfer with b_reg == 0 SHALL be accepted (handshake completes) and discarded; it is not enqueued.
REQ-020 Arbitration per cycle: if stall_a == 0 and a_valid == 1, A is granted; otherwise, if the FIFO is non-empty, the B head is granted and popped.
REQ-021 A grant in cycle N SHALL drive RegWrite/Write_register/Write_data in cycle N+1; when no grant occurs, RegWrite = 0 in N+1 and Write_register/Write_data hold their previous values.
REQ-022 A granted A request with a_reg == 0 SHALL produce RegWrite = 0 in N+1.
REQ-023 An entry pushed in cycle N SHALL be grantable no earlier than N+1; minimum B latency is push-to-RegWrite = 2 cycles.
REQ-024 FIFO order SHALL be strict FIFO; no reordering, no coalescing of same-register writes.
REQ-025 Starvation counter (4 bits): increments each cycle in which the FIFO is non-empty and the head is not granted; clears on head grant or when the FIFO is empty.
REQ-026 When the counter reaches STARVE_LIMIT, stall_a SHALL be 1 in the following cycle; stall_a is high for exactly one cycle per event, the head is granted in that cycle, and the counter clears.
REQ-027 If a_valid == 1 while stall_a == 1, the A request SHALL be dropped (no write), err SHALL set, and B SHALL be granted as normal.
REQ-028 err SHALL remain 1 until reset.
REQ-029 pend_count SHALL reflect post-edge FIFO occupancy, with simultaneous push and pop leaving it unchanged.

Reset
REQ-030 While reset == 0: RegWrite = 0, Write_register = 0, Write_data = 0, stall_a = 0, err = 0, pend_count = 0, b_ready = 0, counter = 0, FIFO empty.
REQ-031 Reset asserted mid-operation SHALL flush queued B writes with no register-file write issued for them.
REQ-032 b_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 A-only: a_valid = 1, a_reg = 5, a_data = 0xDEADBEEF in cycle N -> RegWrite = 1, Write_register = 5, Write_data = 0xDEADBEEF in N+1; RegWrite = 0 in N+2.
REQ-034 B-only: b_valid in N, b_reg = 9, b_data = 0x1234, FIFO empty, a_valid = 0 -> pend_count = 1 in N+1, RegWrite with reg 9 / 0x1234 in N+2, pend_count = 0 in N+2.
REQ-035 Full and register-0 handling: push 2 B entries with a_valid held at 1 -> b_ready = 0 and pend_count = 2; a B transfer with b_reg = 0, and A with a_reg = 0, each -> never RegWrite = 1.
REQ-036 Starvation: STARVE_LIMIT = 4, 1 queued B entry, a_valid held at 1 -> stall_a = 1 exactly 5 cycles after the entry becomes grantable; B write appears in the next cycle; A resumes afterwards.
REQ-037 Violation: a_valid = 1 during stall_a = 1 -> that A write is absent, B is written, and err stays 1 until reset.
REQ-038 Reset mid-operation: 2 entries queued, reset pulled low between edges -> all outputs 0 immediately; no B write after release; b_ready = 1 in the first cycle after release.
